// File: rtl/logic_op_sequencer.sv
// Command FIFO + hold sequencer feeding the 4-bit logical unit's operand/selector inputs.
// Optional replay mode enabled by defining LOGIC_SEQ_LOOP_EN (adds the `loop` input).
module logic_op_sequencer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op1,
    input  logic [3:0]             in_op2,
    input  logic [1:0]             in_sel,
    input  logic [HOLD_W-1:0]      in_hold,
`ifdef LOGIC_SEQ_LOOP_EN
    input  logic                   loop,
`endif
    output logic [3:0]             op1,
    output logic [3:0]             op2,
    output logic [1:0]             sel,
    output logic                   issue,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef struct packed {
        logic [3:0]        op1;
        logic [3:0]        op2;
        logic [1:0]        sel;
        logic [HOLD_W-1:0] hold;
    } cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    cmd_t              fifo_q [DEPTH];
    cmd_t              fifo_d [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        op1_q, op1_d;
    logic [3:0]        op2_q, op2_d;
    logic [1:0]        sel_q, sel_d;
    logic              issue_q, issue_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;

    cmd_t              head;
    logic              push;
    logic              pop;
    logic              recycle;
    logic [AW-1:0]     wr_idx;

    // Next-state: FIFO bookkeeping, hold countdown and issue of the head entry
    always_comb begin
        state_d    = state_q;
        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        level_d    = level_q;
        hold_cnt_d = hold_cnt_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        sel_d      = sel_q;
        issue_d    = 1'b0;
        head       = fifo_q[rd_ptr_q];
        push       = in_valid && in_ready_q;
        pop        = 1'b0;
        recycle    = 1'b0;
        wr_idx     = wr_ptr_q;

        case (state_q)
            IDLE: begin
                pop = (level_q != '0);
            end
            HOLD: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end else if (level_q != '0) begin
                    pop = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            op1_d      = head.op1;
            op2_d      = head.op2;
            sel_d      = head.sel;
            hold_cnt_d = head.hold;
            issue_d    = 1'b1;
            state_d    = HOLD;
            rd_ptr_d   = rd_ptr_q + AW'(1);
        end

`ifdef LOGIC_SEQ_LOOP_EN
        recycle = pop && loop;
`endif

        // External push lands first so a fresh command follows the one just issued
        if (push) begin
            fifo_d[wr_idx] = '{op1: in_op1, op2: in_op2, sel: in_sel, hold: in_hold};
            wr_idx         = wr_idx + AW'(1);
        end
        if (recycle) begin
            fifo_d[wr_idx] = head;
            wr_idx         = wr_idx + AW'(1);
        end
        wr_ptr_d = wr_idx;

        level_d    = level_q + LW'(push) - LW'(pop && !recycle);
        busy_d     = (state_d == HOLD);
        in_ready_d = (level_d != LW'(DEPTH));
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            hold_cnt_q <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            sel_q      <= '0;
            issue_q    <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            hold_cnt_q <= hold_cnt_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            sel_q      <= sel_d;
            issue_q    <= issue_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Storage needs no reset; occupancy is governed by the pointers and level
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign op1      = op1_q;
    assign op2      = op2_q;
    assign sel      = sel_q;
    assign issue    = issue_q;
    assign busy     = busy_q;
    assign level    = level_q;
    assign in_ready = in_ready_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Bench for logic_op_sequencer: queue-based reference model checked every cycle plus directed literal checks.
module tb_logic_op_sequencer;

    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;

    typedef struct packed {
        logic [3:0] op1;
        logic [3:0] op2;
        logic [1:0] sel;
        logic [3:0] hold;
    } cmd_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_op1 = '0;
    logic [3:0] in_op2 = '0;
    logic [1:0] in_sel = '0;
    logic [3:0] in_hold = '0;
`ifdef LOGIC_SEQ_LOOP_EN
    logic       loop = 1'b0;
`endif
    logic [3:0] op1;
    logic [3:0] op2;
    logic [1:0] sel;
    logic       issue;
    logic       busy;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [3:0] m_op1 = '0;
    logic [3:0] m_op2 = '0;
    logic [1:0] m_sel = '0;
    logic       m_issue = 1'b0;
    logic       m_busy = 1'b0;
    int         remain = 0;
    bit         active = 1'b0;
    cmd_t       mq[$];

    logic_op_sequencer #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op1   (in_op1),
        .in_op2   (in_op2),
        .in_sel   (in_sel),
        .in_hold  (in_hold),
`ifdef LOGIC_SEQ_LOOP_EN
        .loop     (loop),
`endif
        .op1      (op1),
        .op2      (op2),
        .sel      (sel),
        .issue    (issue),
        .busy     (busy),
        .level    (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: command queue plus remaining visibility of the current command
    always @(posedge clk) begin
        bit   acc;
        bit   pop;
        bit   lp;
        cmd_t c;
        if (reset) begin
            mq.delete();
            m_op1 = '0; m_op2 = '0; m_sel = '0;
            m_issue = 1'b0; m_busy = 1'b0;
            remain = 0; active = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < DEPTH);
            lp  = 1'b0;
`ifdef LOGIC_SEQ_LOOP_EN
            lp  = loop;
`endif
            pop = 1'b0;
            c   = '0;
            if (active && remain > 0) remain--;
            else if (mq.size() > 0) pop = 1'b1;
            else active = 1'b0;
            m_issue = pop;
            if (pop) begin
                c = mq.pop_front();
                m_op1 = c.op1; m_op2 = c.op2; m_sel = c.sel;
                remain = int'(c.hold);
                active = 1'b1;
            end
            if (acc) mq.push_back('{op1: in_op1, op2: in_op2, sel: in_sel, hold: in_hold});
            if (pop && lp) mq.push_back(c);
            m_busy = active;
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("op1",      8'(op1),      8'(m_op1));
            chk("op2",      8'(op2),      8'(m_op2));
            chk("sel",      8'(sel),      8'(m_sel));
            chk("issue",    8'(issue),    8'(m_issue));
            chk("busy",     8'(busy),     8'(m_busy));
            chk("level",    8'(level),    8'(mq.size()));
            chk("in_ready", 8'(in_ready), 8'(mq.size() < DEPTH));
        end
    end

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] s, input logic [3:0] h);
        in_valid = v; in_op1 = a; in_op2 = b; in_sel = s; in_hold = h;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 2'b00, 4'h0);
        repeat (n) @(negedge clk);
        chk("rst_op1",   8'(op1),      8'h00);
        chk("rst_op2",   8'(op2),      8'h00);
        chk("rst_sel",   8'(sel),      8'h00);
        chk("rst_issue", 8'(issue),    8'h00);
        chk("rst_busy",  8'(busy),     8'h00);
        chk("rst_level", 8'(level),    8'h00);
        chk("rst_ready", 8'(in_ready), 8'h01);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n_iss;
        int         first;
        int         last;
        int         max_lvl;
        int         good;
        bit         saw_f;
        bit         drained;
        logic [7:0] seq;

        do_reset(2);
        chk_en = 1'b1;

        // Arbitrary traffic then reset
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 4'(i + 3), 4'(i), 2'(i), 4'h3);
        end
        @(negedge clk);
        drive(1'b0, 4'h0, 4'h0, 2'b00, 4'h0);
        repeat (3) @(negedge clk);
        do_reset(2);

        // Single command: A/5/01 hold 2
        @(negedge clk);
        drive(1'b1, 4'hA, 4'h5, 2'b01, 4'h2);
        @(negedge clk);
        chk("s_level1", 8'(level), 8'h01);
        chk("s_noissue", 8'(issue), 8'h00);
        drive(1'b0, 4'h0, 4'h0, 2'b00, 4'h0);
        @(negedge clk);
        chk("s_op1", 8'(op1), 8'h0A);
        chk("s_op2", 8'(op2), 8'h05);
        chk("s_sel", 8'(sel), 8'h01);
        chk("s_issue", 8'(issue), 8'h01);
        chk("s_busy0", 8'(busy), 8'h01);
        @(negedge clk);
        chk("s_busy1", 8'(busy), 8'h01);
        chk("s_issue_low", 8'(issue), 8'h00);
        @(negedge clk);
        chk("s_busy2", 8'(busy), 8'h01);
        @(negedge clk);
        chk("s_idle", 8'(busy), 8'h00);
        chk("s_keep_op1", 8'(op1), 8'h0A);
        chk("s_keep_sel", 8'(sel), 8'h01);

        // Back-to-back hold=0, sels 00..11
        do_reset(1);
        n_iss = 0; first = -1; last = -1; seq = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (issue) begin
                n_iss++;
                seq = {sel, seq[7:2]};
                if (first < 0) first = i;
                last = i;
            end
            if (i < 4) drive(1'b1, 4'(i + 1), 4'(9 - i), 2'(i), 4'h0);
            else drive(1'b0, 4'h0, 4'h0, 2'b00, 4'h0);
        end
        chk("b2b_count", 8'(n_iss), 8'd4);
        chk("b2b_seq", seq, 8'hE4);
        chk("b2b_span", 8'(last - first + 1), 8'd4);

        // Full / backpressure: first hold 15, six commands, sixth held offered
        do_reset(1);
        n_iss = 0; max_lvl = 0; saw_f = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (issue) begin
                n_iss++;
                if (op1 == 4'hF) saw_f = 1'b1;
            end
            if (i == 8) begin
                chk("full_level", 8'(level), 8'd4);
                chk("full_ready", 8'(in_ready), 8'h00);
            end
            if (i == 0) drive(1'b1, 4'h1, 4'h0, 2'b00, 4'hF);
            else if (i < 5) drive(1'b1, 4'(i + 1), 4'h0, 2'(i), 4'h0);
            else if (i < 9) drive(1'b1, 4'hF, 4'hF, 2'b11, 4'h0);
            else drive(1'b0, 4'h0, 4'h0, 2'b00, 4'h0);
        end
        drained = 1'b0;
        for (int i = 0; i < 80 && !drained; i++) begin
            @(negedge clk);
            if (int'(level) > max_lvl) max_lvl = int'(level);
            if (issue) begin
                n_iss++;
                if (op1 == 4'hF) saw_f = 1'b1;
            end
            if (level == 3'd0 && !busy) drained = 1'b1;
        end
        chk("full_drained", 8'(drained), 8'h01);
        chk("full_max_level", 8'(max_lvl), 8'd4);
        chk("full_issues", 8'(n_iss), 8'd5);
        chk("full_sixth_rejected", 8'(saw_f), 8'h00);

        // Reset while holding with counter=5 and three queued
        do_reset(1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b1, 4'h7, 4'h1, 2'b10, 4'h9);
            else if (i < 4) drive(1'b1, 4'(i + 8), 4'h2, 2'b01, 4'h0);
            else drive(1'b0, 4'h0, 4'h0, 2'b00, 4'h0);
        end
        @(negedge clk);
        chk("mid_level3", 8'(level), 8'd3);
        chk("mid_busy", 8'(busy), 8'h01);
        chk("mid_op1", 8'(op1), 8'h07);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", 8'(busy), 8'h00);
        chk("mid_rst_level", 8'(level), 8'h00);
        reset = 1'b0;
        n_iss = 0;
        repeat (10) begin
            @(negedge clk);
            if (issue) n_iss++;
        end
        chk("mid_no_issue", 8'(n_iss), 8'd0);

`ifdef LOGIC_SEQ_LOOP_EN
        // Replay of two commands, then drain
        do_reset(1);
        @(negedge clk);
        loop = 1'b1;
        drive(1'b1, 4'hA, 4'h1, 2'b01, 4'h0);
        @(negedge clk);
        drive(1'b1, 4'hB, 4'h2, 2'b10, 4'h0);
        good = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b0, 4'h0, 4'h0, 2'b00, 4'h0);
            if (issue && level == 3'd2 && op1 == ((i % 2 == 0) ? 4'hA : 4'hB)) good++;
        end
        chk("loop_alternate", 8'(good), 8'd10);
        loop = 1'b0;
        n_iss = 0; drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            @(negedge clk);
            if (issue) n_iss++;
            if (level == 3'd0 && !busy) drained = 1'b1;
        end
        chk("loop_drained", 8'(drained), 8'h01);
        chk("loop_drain_issues", 8'(n_iss), 8'd2);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
